deco_stage_pipe: RTL and testbench
==================================

Name: deco_stage_pipe

Overview:
Parametrised RV32I decode stage: a successor to the flat decode block, with an integrated ID/EX pipeline register.
- Decodes the instruction, generates I/S/B/U/J immediates, reads an internal register file with write-back bypass, and produces WB/MEM/EXE control bundles.
- Detects load-use hazards and stalls upstream. Supports a downstream back-pressure and flush handshake.
- Sits between the fetch register and the execute stage.

Parameters:
XLEN, 32, datapath and register width (>=32)
AW, 5, register index width; register count = 2**AW
EN_BYPASS, 1, 1 = same-cycle write-back data forwarded to the read ports

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
in_valid  in  1  fetch presents an instruction
in_instr  in  32  instruction word
in_pc  in  XLEN  instruction PC
id_ready  out  1  stage accepts in_instr this cycle
wb_en  in  1  register write enable from write-back
wb_rd  in  AW  write-back destination
wb_data  in  XLEN  write-back data
ex_ready  in  1  execute stage accepts the output register
flush  in  1  kill the output register and the accepted input (branch taken)
out_valid  out  1  output register holds a live instruction
out_pc  out  XLEN  registered PC
out_rs1_data, out_rs2_data  out  XLEN  registered operands
out_imm  out  XLEN  registered sign-extended immediate
out_rs1, out_rs2, out_rd  out  AW  registered register indices
out_funct3  out  3  registered funct3
out_funct7  out  7  registered funct7
out_wb  out  2  {MemtoReg, RegWrite}
out_mem  out  5  {BrType[1:0], MemWrite, MemRead, Branch}
out_exe  out  3  {AluOp[1:0], AluSrc}
out_illegal  out  1  registered unsupported-opcode flag
dbg_sel  in  AW  debug register select
dbg_data  out  XLEN  combinational, un-bypassed register file read

Behaviour:
Reset (rst=0, asynchronous):
- All out_* go to 0, including out_valid.
- All register file entries go to 0.
- Reset mid-stall discards the held instruction.

Register file:
- Write on the clock edge when wb_en=1 and wb_rd!=0. x0 always reads 0.
- Bypass (EN_BYPASS=1): a read index equal to wb_rd (nonzero, wb_en=1) returns wb_data in the same cycle.
- EN_BYPASS=0: the read returns the old value.

Decode, by opcode in_instr[6:0] (signals not listed are 0):
- 0110011 R-type: RegWrite, AluOp=10.
- 0010011 I-ALU: RegWrite, AluOp=10, AluSrc.
- 0000011 LOAD: RegWrite, MemtoReg, MemRead, AluSrc.
- 0100011 STORE: MemWrite, AluSrc.
- 1100011 BRANCH: Branch, AluOp=01.
- 0110111 LUI: RegWrite, AluOp=11, AluSrc.
- 1101111 JAL: RegWrite, Branch, AluOp=11, AluSrc.
- Any other opcode: all controls 0, out_illegal=1.

BrType:
- Set only for BRANCH: funct3 000 -> 01, 001 -> 10, 100 -> 11, else 00.
- 00 for every non-branch opcode.

Immediates, sign-extended from instr[31] to XLEN:
- I: instr[31:20]
- S: {instr[31:25], instr[11:7]}
- B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}
- U: {instr[31:12], 12'b0}
- J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}
- R-type: 0.

Load-use hazard (combinational):
- Condition: in_valid & out_valid & out_mem[1] & out_rd!=0, and out_rd matches a used source.
- rs1 is used by every opcode except LUI and JAL.
- rs2 is used by R-type, STORE and BRANCH.

Output register update, one rising edge, in priority order:
1. flush=1: out_valid<=0 and all control bundles <=0; the input is consumed, not captured.
2. out_valid & !ex_ready: hold all out_*.
3. Hazard: insert a bubble (out_valid<=0, controls <=0); the input is not consumed.
4. in_valid: capture the decoded instruction, out_valid<=1.
5. Otherwise: out_valid<=0.

Handshake and latency:
- id_ready = flush | (!(out_valid & !ex_ready) & !hazard).
- An instruction is accepted when in_valid & id_ready. Latency is 1 cycle from acceptance to out_valid.
- A load-use dependency costs exactly one bubble cycle when ex_ready=1.
- Write-back to rs in the same cycle as capture stores the bypassed value.

Test Plan:
- Reset, then write x5=0x0000_00AA via wb; decode ADD x3,x5,x0 -> next cycle out_valid=1, out_rs1_data=0xAA, out_wb=01, out_exe=100.
- BEQ with imm -8 (instr 0xFE000CE3) -> out_imm=0xFFFF_FFF8, out_mem=01001; BNE -> BrType 10; funct3 000 with I-ALU opcode -> BrType 00.
- LW x7,0(x1) followed by ADD x8,x7,x2 -> cycle 1 id_ready=0 and bubble (out_valid=0); cycle 2 ADD captured; no stall if the ADD used x0 only or the load rd=0.
- ex_ready=0 for 3 cycles with out_valid=1 -> out_* stable, id_ready=0; flush during the hold -> out_valid=0 on the next edge.
- wb_en=1, wb_rd=4, wb_data=0x1234 in the same cycle that ADDI x9,x4,1 is decoded -> out_rs1_data=0x1234 (EN_BYPASS=1), old value with EN_BYPASS=0; a write to x0 keeps dbg_data(0)=0.
- Assert rst low while a load-use stall is pending -> all outputs 0 immediately (asynchronously); opcode 0x7F -> out_illegal=1, controls 0.

Source files
------------

// File: rtl/deco_stage_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : deco_stage_pipe
//  Description : RV32I decode stage with an integrated ID/EX pipeline
//                register. Decodes the fetched instruction, builds the
//                sign-extended immediate, reads a 2**AW entry register file
//                (optionally forwarding same-cycle write-back data), builds
//                the WB/MEM/EXE control bundles and registers everything
//                for the execute stage. Load-use hazards stall the fetch
//                side for one cycle; ex_ready back-pressure holds the output
//                register; flush kills both the output register and the
//                instruction being offered.
//
//  Ports
//    clk            : clock, all state updates on the rising edge
//    rst            : asynchronous reset, active low
//    in_valid       : fetch offers in_instr / in_pc
//    in_instr       : 32-bit instruction word
//    in_pc          : instruction PC
//    id_ready       : stage accepts the offered instruction this cycle
//    wb_en/wb_rd/wb_data : register file write port from write-back
//    ex_ready       : execute stage takes the output register this cycle
//    flush          : kill output register and offered instruction
//    out_*          : registered ID/EX payload (see declarations)
//    dbg_sel        : debug read select
//    dbg_data       : raw register file contents (no forwarding)
//
//  Revision    : 1.0 - initial release
// ============================================================================
module deco_stage_pipe #(
    parameter int XLEN      = 32,
    parameter int AW        = 5,
    parameter int EN_BYPASS = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            id_ready,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            ex_ready,
    input  logic            flush,
    output logic            out_valid,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_rs1_data,
    output logic [XLEN-1:0] out_rs2_data,
    output logic [XLEN-1:0] out_imm,
    output logic [AW-1:0]   out_rs1,
    output logic [AW-1:0]   out_rs2,
    output logic [AW-1:0]   out_rd,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [1:0]      out_wb,
    output logic [4:0]      out_mem,
    output logic [2:0]      out_exe,
    output logic            out_illegal,
    input  logic [AW-1:0]   dbg_sel,
    output logic [XLEN-1:0] dbg_data
);

    // ------------------------------------------------------------------
    // Opcodes
    // ------------------------------------------------------------------
    localparam logic [6:0] c_OP_R      = 7'b0110011;
    localparam logic [6:0] c_OP_IALU   = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;

    localparam int c_NREG = 2**AW;

    // ------------------------------------------------------------------
    // Instruction fields
    // ------------------------------------------------------------------
    logic [6:0]    opcode;
    logic [2:0]    funct3;
    logic [6:0]    funct7;
    logic [AW-1:0] rs1_idx;
    logic [AW-1:0] rs2_idx;
    logic [AW-1:0] rd_idx;

    assign opcode  = in_instr[6:0];
    assign funct3  = in_instr[14:12];
    assign funct7  = in_instr[31:25];
    assign rs1_idx = AW'(in_instr[19:15]);
    assign rs2_idx = AW'(in_instr[24:20]);
    assign rd_idx  = AW'(in_instr[11:7]);

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    logic       ctl_mem_to_reg;
    logic       ctl_reg_write;
    logic [1:0] ctl_br_type;
    logic       ctl_mem_write;
    logic       ctl_mem_read;
    logic       ctl_branch;
    logic [1:0] ctl_alu_op;
    logic       ctl_alu_src;
    logic       ctl_illegal;
    logic       use_rs1;
    logic       use_rs2;

    // Immediate format selector
    localparam logic [2:0] c_IMM_NONE = 3'd0;
    localparam logic [2:0] c_IMM_I    = 3'd1;
    localparam logic [2:0] c_IMM_S    = 3'd2;
    localparam logic [2:0] c_IMM_B    = 3'd3;
    localparam logic [2:0] c_IMM_U    = 3'd4;
    localparam logic [2:0] c_IMM_J    = 3'd5;
    logic [2:0] imm_sel;

    always_comb begin
        ctl_mem_to_reg = 1'b0;
        ctl_reg_write  = 1'b0;
        ctl_br_type    = 2'b00;
        ctl_mem_write  = 1'b0;
        ctl_mem_read   = 1'b0;
        ctl_branch     = 1'b0;
        ctl_alu_op     = 2'b00;
        ctl_alu_src    = 1'b0;
        ctl_illegal    = 1'b0;
        use_rs1        = 1'b1;
        use_rs2        = 1'b0;
        imm_sel        = c_IMM_NONE;
        case (opcode)
            c_OP_R: begin
                ctl_reg_write = 1'b1;
                ctl_alu_op    = 2'b10;
                use_rs2       = 1'b1;
            end
            c_OP_IALU: begin
                ctl_reg_write = 1'b1;
                ctl_alu_op    = 2'b10;
                ctl_alu_src   = 1'b1;
                imm_sel       = c_IMM_I;
            end
            c_OP_LOAD: begin
                ctl_reg_write  = 1'b1;
                ctl_mem_to_reg = 1'b1;
                ctl_mem_read   = 1'b1;
                ctl_alu_src    = 1'b1;
                imm_sel        = c_IMM_I;
            end
            c_OP_STORE: begin
                ctl_mem_write = 1'b1;
                ctl_alu_src   = 1'b1;
                use_rs2       = 1'b1;
                imm_sel       = c_IMM_S;
            end
            c_OP_BRANCH: begin
                ctl_branch = 1'b1;
                ctl_alu_op = 2'b01;
                use_rs2    = 1'b1;
                imm_sel    = c_IMM_B;
                case (funct3)
                    3'b000:  ctl_br_type = 2'b01;
                    3'b001:  ctl_br_type = 2'b10;
                    3'b100:  ctl_br_type = 2'b11;
                    default: ctl_br_type = 2'b00;
                endcase
            end
            c_OP_LUI: begin
                ctl_reg_write = 1'b1;
                ctl_alu_op    = 2'b11;
                ctl_alu_src   = 1'b1;
                use_rs1       = 1'b0;
                imm_sel       = c_IMM_U;
            end
            c_OP_JAL: begin
                ctl_reg_write = 1'b1;
                ctl_branch    = 1'b1;
                ctl_alu_op    = 2'b11;
                ctl_alu_src   = 1'b1;
                use_rs1       = 1'b0;
                imm_sel       = c_IMM_J;
            end
            default: begin
                ctl_illegal = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Immediate generation: build a 32-bit value, then sign-extend to XLEN
    // ------------------------------------------------------------------
    logic [31:0]     imm32;
    logic [XLEN-1:0] imm_ext;

    always_comb begin
        case (imm_sel)
            c_IMM_I: imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            c_IMM_S: imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            c_IMM_B: imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                              in_instr[30:25], in_instr[11:8], 1'b0};
            c_IMM_U: imm32 = {in_instr[31:12], 12'b0};
            c_IMM_J: imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                              in_instr[20], in_instr[30:21], 1'b0};
            default: imm32 = 32'b0;
        endcase
    end

    always_comb begin
        imm_ext       = {XLEN{imm32[31]}};
        imm_ext[31:0] = imm32;
    end

    // ------------------------------------------------------------------
    // Register file. Entry 0 is never written, so it always reads zero.
    // ------------------------------------------------------------------
    logic [XLEN-1:0] rf_q [c_NREG];
    logic [XLEN-1:0] rf_d [c_NREG];
    logic            wb_write;

    assign wb_write = wb_en && (wb_rd != '0);

    always_comb begin
        rf_d = rf_q;
        if (wb_write) begin
            rf_d[wb_rd] = wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < c_NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            rf_q <= rf_d;
        end
    end

    // Same-cycle write-back forwarding onto the operand read ports
    logic byp_rs1;
    logic byp_rs2;

    generate
        if (EN_BYPASS != 0) begin : g_bypass
            assign byp_rs1 = wb_write && (wb_rd == rs1_idx);
            assign byp_rs2 = wb_write && (wb_rd == rs2_idx);
        end else begin : g_no_bypass
            assign byp_rs1 = 1'b0;
            assign byp_rs2 = 1'b0;
        end
    endgenerate

    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;

    assign rs1_val  = byp_rs1 ? wb_data : rf_q[rs1_idx];
    assign rs2_val  = byp_rs2 ? wb_data : rf_q[rs2_idx];
    assign dbg_data = rf_q[dbg_sel];

    // ------------------------------------------------------------------
    // ID/EX output register state
    // ------------------------------------------------------------------
    logic            valid_q,   valid_d;
    logic [XLEN-1:0] pc_q,      pc_d;
    logic [XLEN-1:0] rs1_data_q, rs1_data_d;
    logic [XLEN-1:0] rs2_data_q, rs2_data_d;
    logic [XLEN-1:0] imm_q,     imm_d;
    logic [AW-1:0]   rs1_q,     rs1_d;
    logic [AW-1:0]   rs2_q,     rs2_d;
    logic [AW-1:0]   rd_q,      rd_d;
    logic [2:0]      funct3_q,  funct3_d;
    logic [6:0]      funct7_q,  funct7_d;
    logic [1:0]      wb_q,      wb_d;
    logic [4:0]      mem_q,     mem_d;
    logic [2:0]      exe_q,     exe_d;
    logic            illegal_q, illegal_d;

    // ------------------------------------------------------------------
    // Hazard / handshake
    // ------------------------------------------------------------------
    logic hold;
    logic hazard;

    // Output register is occupied and execute cannot take it
    assign hold = valid_q && !ex_ready;

    // Previous instruction is a load whose result is not yet available;
    // only compare against sources the new instruction actually reads.
    assign hazard = in_valid && valid_q && mem_q[1] && (rd_q != '0) &&
                    ((use_rs1 && (rs1_idx == rd_q)) ||
                     (use_rs2 && (rs2_idx == rd_q)));

    // A flush consumes the offered instruction even under hold or hazard
    assign id_ready = flush || (!hold && !hazard);

    always_comb begin
        valid_d    = valid_q;
        pc_d       = pc_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        imm_d      = imm_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rd_d       = rd_q;
        funct3_d   = funct3_q;
        funct7_d   = funct7_q;
        wb_d       = wb_q;
        mem_d      = mem_q;
        exe_d      = exe_q;
        illegal_d  = illegal_q;

        if (flush || (!hold && (hazard || !in_valid))) begin
            // Flush, load-use bubble, or nothing to capture: emit an
            // empty slot with all side-effecting controls cleared.
            valid_d   = 1'b0;
            wb_d      = 2'b00;
            mem_d     = 5'b00000;
            exe_d     = 3'b000;
            illegal_d = 1'b0;
        end else if (!hold) begin
            valid_d    = 1'b1;
            pc_d       = in_pc;
            rs1_data_d = rs1_val;
            rs2_data_d = rs2_val;
            imm_d      = imm_ext;
            rs1_d      = rs1_idx;
            rs2_d      = rs2_idx;
            rd_d       = rd_idx;
            funct3_d   = funct3;
            funct7_d   = funct7;
            wb_d       = {ctl_mem_to_reg, ctl_reg_write};
            mem_d      = {ctl_br_type, ctl_mem_write, ctl_mem_read, ctl_branch};
            exe_d      = {ctl_alu_op, ctl_alu_src};
            illegal_d  = ctl_illegal;
        end
        // hold: every field keeps its value
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            funct3_q   <= '0;
            funct7_q   <= '0;
            wb_q       <= '0;
            mem_q      <= '0;
            exe_q      <= '0;
            illegal_q  <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
            funct3_q   <= funct3_d;
            funct7_q   <= funct7_d;
            wb_q       <= wb_d;
            mem_q      <= mem_d;
            exe_q      <= exe_d;
            illegal_q  <= illegal_d;
        end
    end

    assign out_valid    = valid_q;
    assign out_pc       = pc_q;
    assign out_rs1_data = rs1_data_q;
    assign out_rs2_data = rs2_data_q;
    assign out_imm      = imm_q;
    assign out_rs1      = rs1_q;
    assign out_rs2      = rs2_q;
    assign out_rd       = rd_q;
    assign out_funct3   = funct3_q;
    assign out_funct7   = funct7_q;
    assign out_wb       = wb_q;
    assign out_mem      = mem_q;
    assign out_exe      = exe_q;
    assign out_illegal  = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_deco_stage_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_deco_stage_pipe
//  Description : Self-checking bench for deco_stage_pipe. Two instances share
//                all inputs: one with forwarding, one without. Expected ID/EX
//                payloads are queued on acceptance and compared when the
//                execute side takes the output register.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_deco_stage_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        id_ready;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        ex_ready;
    logic        flush;
    logic        out_valid;
    logic [31:0] out_pc, out_rs1_data, out_rs2_data, out_imm;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic [2:0]  out_funct3;
    logic [6:0]  out_funct7;
    logic [1:0]  out_wb;
    logic [4:0]  out_mem;
    logic [2:0]  out_exe;
    logic        out_illegal;
    logic [4:0]  dbg_sel;
    logic [31:0] dbg_data;

    // No-forwarding instance outputs
    logic        nb_id_ready, nb_out_valid, nb_out_illegal;
    logic [31:0] nb_out_pc, nb_out_rs1_data, nb_out_rs2_data, nb_out_imm, nb_dbg_data;
    logic [4:0]  nb_out_rs1, nb_out_rs2, nb_out_rd, nb_out_mem;
    logic [2:0]  nb_out_funct3, nb_out_exe;
    logic [6:0]  nb_out_funct7;
    logic [1:0]  nb_out_wb;

    deco_stage_pipe #(.XLEN(32), .AW(5), .EN_BYPASS(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr),
        .in_pc(in_pc), .id_ready(id_ready), .wb_en(wb_en), .wb_rd(wb_rd),
        .wb_data(wb_data), .ex_ready(ex_ready), .flush(flush),
        .out_valid(out_valid), .out_pc(out_pc), .out_rs1_data(out_rs1_data),
        .out_rs2_data(out_rs2_data), .out_imm(out_imm), .out_rs1(out_rs1),
        .out_rs2(out_rs2), .out_rd(out_rd), .out_funct3(out_funct3),
        .out_funct7(out_funct7), .out_wb(out_wb), .out_mem(out_mem),
        .out_exe(out_exe), .out_illegal(out_illegal), .dbg_sel(dbg_sel),
        .dbg_data(dbg_data)
    );

    deco_stage_pipe #(.XLEN(32), .AW(5), .EN_BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr),
        .in_pc(in_pc), .id_ready(nb_id_ready), .wb_en(wb_en), .wb_rd(wb_rd),
        .wb_data(wb_data), .ex_ready(ex_ready), .flush(flush),
        .out_valid(nb_out_valid), .out_pc(nb_out_pc), .out_rs1_data(nb_out_rs1_data),
        .out_rs2_data(nb_out_rs2_data), .out_imm(nb_out_imm), .out_rs1(nb_out_rs1),
        .out_rs2(nb_out_rs2), .out_rd(nb_out_rd), .out_funct3(nb_out_funct3),
        .out_funct7(nb_out_funct7), .out_wb(nb_out_wb), .out_mem(nb_out_mem),
        .out_exe(nb_out_exe), .out_illegal(nb_out_illegal), .dbg_sel(dbg_sel),
        .dbg_data(nb_dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1d;
        logic [31:0] rs2d;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [1:0]  wb;
        logic [4:0]  mem;
        logic [2:0]  exe;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    exp_t cur_exp;
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] rs1d, input logic [31:0] rs2d,
                                input logic [31:0] imm, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [4:0] rd,
                                input logic [2:0] f3, input logic [6:0] f7,
                                input logic [1:0] wb, input logic [4:0] mem,
                                input logic [2:0] exe, input logic ill);
        exp_t e;
        e.pc = 32'h0; e.rs1d = rs1d; e.rs2d = rs2d; e.imm = imm;
        e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.f3 = f3; e.f7 = f7;
        e.wb = wb; e.mem = mem; e.exe = exe; e.ill = ill;
        return e;
    endfunction

    // Scoreboard monitor: sampled on the falling edge, so values describe
    // what happens at the following rising edge.
    always @(negedge clk) begin
        if (rst) begin
            if (out_valid && flush) begin
                if (sb.size() > 0) sb.delete(0);
            end else if (out_valid && ex_ready) begin
                if (sb.size() == 0) begin
                    check_val("sb_unexpected_output", {32'h0, out_pc}, 64'hFFFF_FFFF);
                end else begin
                    mon_e = sb.pop_front();
                    check_val("sb_pc",      out_pc,       mon_e.pc);
                    check_val("sb_rs1data", out_rs1_data, mon_e.rs1d);
                    check_val("sb_rs2data", out_rs2_data, mon_e.rs2d);
                    check_val("sb_imm",     out_imm,      mon_e.imm);
                    check_val("sb_rs1",     out_rs1,      mon_e.rs1);
                    check_val("sb_rs2",     out_rs2,      mon_e.rs2);
                    check_val("sb_rd",      out_rd,       mon_e.rd);
                    check_val("sb_funct3",  out_funct3,   mon_e.f3);
                    check_val("sb_funct7",  out_funct7,   mon_e.f7);
                    check_val("sb_wb",      out_wb,       mon_e.wb);
                    check_val("sb_mem",     out_mem,      mon_e.mem);
                    check_val("sb_exe",     out_exe,      mon_e.exe);
                    check_val("sb_illegal", out_illegal,  mon_e.ill);
                end
            end
            if (in_valid && id_ready && !flush) sb.push_back(cur_exp);
        end
    end

    // Offer one instruction and hold it until accepted (bounded wait).
    task automatic issue(input logic [31:0] instr, input logic [31:0] pc, input exp_t e,
                         output int stalls, output logic ov_acc);
        logic done;
        exp_t ee;
        ee = e;
        ee.pc = pc;
        in_valid = 1'b1; in_instr = instr; in_pc = pc; cur_exp = ee;
        stalls = 0; ov_acc = 1'b0; done = 1'b0;
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge clk);
            if (id_ready) begin
                done = 1'b1;
                ov_acc = out_valid;
            end else begin
                stalls++;
            end
        end
        if (!done) check_val("accept_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wb_write(input logic [4:0] rd, input logic [31:0] d);
        wb_en = 1'b1; wb_rd = rd; wb_data = d;
        @(posedge clk); #1;
        wb_en = 1'b0;
    endtask

    // Instruction encodings
    localparam logic [31:0] I_ADD_3_5_0   = 32'h0002_81B3;
    localparam logic [31:0] I_BEQ_M8      = 32'hFE00_0CE3;
    localparam logic [31:0] I_BNE_M8      = 32'hFE00_1CE3;
    localparam logic [31:0] I_ADDI_11_5_M1 = 32'hFFF2_8593;
    localparam logic [31:0] I_LUI_12      = 32'h8000_0637;
    localparam logic [31:0] I_JAL_1_16    = 32'h0100_00EF;
    localparam logic [31:0] I_ILLEGAL     = 32'h0000_007F;
    localparam logic [31:0] I_ADDI_9_4_1  = 32'h0012_0493;
    localparam logic [31:0] I_LW_7_1      = 32'h0000_A383;
    localparam logic [31:0] I_ADD_8_7_2   = 32'h0023_8433;
    localparam logic [31:0] I_ADD_8_0_0   = 32'h0000_0433;
    localparam logic [31:0] I_LW_0_1      = 32'h0000_A003;
    localparam logic [31:0] I_LUI_10      = 32'h0003_8537;
    localparam logic [31:0] I_SW_7_4_1    = 32'h0070_A223;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        int   st;
        logic ova;
        exp_t e_add3, e_lw7, e_add8_0;

        rst = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
        wb_en = 1'b0; wb_rd = '0; wb_data = '0; ex_ready = 1'b1; flush = 1'b0;
        dbg_sel = '0; cur_exp = '0;

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_out_pc",    out_pc, 0);
        check_val("rst_out_ctl",   {out_wb, out_mem, out_exe, out_illegal}, 0);
        check_val("rst_out_imm",   out_imm, 0);
        rst = 1'b1;
        @(posedge clk); #1;

        // ---------------- register file preload ----------------
        wb_write(5'd5, 32'h0000_00AA);
        wb_write(5'd1, 32'h0000_0100);
        wb_write(5'd2, 32'h0000_0022);
        wb_write(5'd4, 32'h0000_0055);
        wb_write(5'd0, 32'h0000_FFFF);
        dbg_sel = 5'd5; #1;
        check_val("dbg_x5", dbg_data, 32'hAA);
        dbg_sel = 5'd0; #1;
        check_val("dbg_x0_after_write", dbg_data, 0);
        check_val("nb_dbg_x0_after_write", nb_dbg_data, 0);

        // ---------------- basic decode ----------------
        e_add3 = mk(32'hAA, 0, 0, 5, 0, 3, 0, 0, 2'b01, 5'b00000, 3'b100, 0);
        issue(I_ADD_3_5_0, 32'h1000, e_add3, st, ova);
        check_val("add_lat_valid", out_valid, 1);
        check_val("add_lat_rs1d",  out_rs1_data, 32'hAA);
        check_val("add_lat_wb",    out_wb, 2'b01);
        check_val("add_lat_exe",   out_exe, 3'b100);

        issue(I_BEQ_M8, 32'h1004,
              mk(0, 0, 32'hFFFF_FFF8, 0, 0, 25, 3'd0, 7'h7F, 2'b00, 5'b01001, 3'b010, 0), st, ova);
        issue(I_BNE_M8, 32'h1008,
              mk(0, 0, 32'hFFFF_FFF8, 0, 0, 25, 3'd1, 7'h7F, 2'b00, 5'b10001, 3'b010, 0), st, ova);
        issue(I_ADDI_11_5_M1, 32'h100C,
              mk(32'hAA, 0, 32'hFFFF_FFFF, 5, 31, 11, 3'd0, 7'h7F, 2'b01, 5'b00000, 3'b101, 0), st, ova);
        issue(I_LUI_12, 32'h1010,
              mk(0, 0, 32'h8000_0000, 0, 0, 12, 3'd0, 7'h40, 2'b01, 5'b00000, 3'b111, 0), st, ova);
        issue(I_JAL_1_16, 32'h1014,
              mk(0, 0, 32'h10, 0, 16, 1, 3'd0, 7'h00, 2'b01, 5'b00001, 3'b111, 0), st, ova);
        issue(I_ILLEGAL, 32'h1018,
              mk(0, 0, 0, 0, 0, 0, 3'd0, 7'h00, 2'b00, 5'b00000, 3'b000, 1), st, ova);

        // ---------------- same-cycle write-back forwarding ----------------
        wb_en = 1'b1; wb_rd = 5'd4; wb_data = 32'h1234;
        issue(I_ADDI_9_4_1, 32'h101C,
              mk(32'h1234, 32'h100, 32'h1, 4, 1, 9, 3'd0, 7'h00, 2'b01, 5'b00000, 3'b101, 0), st, ova);
        wb_en = 1'b0;
        check_val("byp_rs1_data",   out_rs1_data, 32'h1234);
        check_val("nobyp_rs1_data", nb_out_rs1_data, 32'h55);
        dbg_sel = 5'd4; #1;
        check_val("byp_dbg_x4",   dbg_data, 32'h1234);
        check_val("nobyp_dbg_x4", nb_dbg_data, 32'h1234);

        // ---------------- load-use hazards ----------------
        e_lw7    = mk(32'h100, 0, 0, 1, 0, 7, 3'd2, 7'h00, 2'b11, 5'b00010, 3'b001, 0);
        e_add8_0 = mk(0, 0, 0, 0, 0, 8, 3'd0, 7'h00, 2'b01, 5'b00000, 3'b100, 0);

        issue(I_LW_7_1, 32'h1020, e_lw7, st, ova);
        issue(I_ADD_8_7_2, 32'h1024,
              mk(0, 32'h22, 0, 7, 2, 8, 3'd0, 7'h00, 2'b01, 5'b00000, 3'b100, 0), st, ova);
        check_val("lu_rs1_stalls", st, 1);
        check_val("lu_rs1_bubble", ova, 0);

        issue(I_LW_7_1, 32'h1028, e_lw7, st, ova);
        issue(I_ADD_8_0_0, 32'h102C, e_add8_0, st, ova);
        check_val("lu_x0_src_stalls", st, 0);

        issue(I_LW_0_1, 32'h1030,
              mk(32'h100, 0, 0, 1, 0, 0, 3'd2, 7'h00, 2'b11, 5'b00010, 3'b001, 0), st, ova);
        issue(I_ADD_8_0_0, 32'h1034, e_add8_0, st, ova);
        check_val("lu_rd0_stalls", st, 0);

        issue(I_LW_7_1, 32'h1038, e_lw7, st, ova);
        issue(I_LUI_10, 32'h103C,
              mk(0, 0, 32'h0003_8000, 7, 0, 10, 3'd0, 7'h00, 2'b01, 5'b00000, 3'b111, 0), st, ova);
        check_val("lu_lui_stalls", st, 0);
        check_val("lu_lui_nobubble", ova, 1);

        issue(I_LW_7_1, 32'h1040, e_lw7, st, ova);
        issue(I_SW_7_4_1, 32'h1044,
              mk(32'h100, 0, 32'h4, 1, 7, 4, 3'd2, 7'h00, 2'b00, 5'b00100, 3'b001, 0), st, ova);
        check_val("lu_rs2_stalls", st, 1);

        @(posedge clk); #1;
        @(posedge clk); #1;
        check_val("idle_out_valid", out_valid, 0);

        // ---------------- back-pressure hold, then flush ----------------
        ex_ready = 1'b0;
        issue(I_ADD_3_5_0, 32'h1048, e_add3, st, ova);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("hold_id_ready", id_ready, 0);
            @(posedge clk); #1;
            check_val("hold_valid", out_valid, 1);
            check_val("hold_pc",    out_pc, 32'h1048);
            check_val("hold_rd",    out_rd, 3);
            check_val("hold_rs1d",  out_rs1_data, 32'hAA);
        end
        flush = 1'b1; in_valid = 1'b1; in_instr = I_ADDI_11_5_M1; in_pc = 32'h104C;
        @(negedge clk);
        check_val("flush_id_ready", id_ready, 1);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0; ex_ready = 1'b1;
        check_val("flush_out_valid", out_valid, 0);
        @(posedge clk); #1;
        check_val("flush_not_captured", out_valid, 0);
        check_val("sb_drained", sb.size(), 0);

        // ---------------- asynchronous reset during a pending stall ----------------
        issue(I_LW_7_1, 32'h1050, e_lw7, st, ova);
        in_valid = 1'b1; in_instr = I_ADD_8_7_2; in_pc = 32'h1054;
        dbg_sel = 5'd5;
        @(negedge clk);
        check_val("stall_pending", id_ready, 0);
        #2;
        rst = 1'b0;
        #1;
        check_val("arst_valid", out_valid, 0);
        check_val("arst_pc",    out_pc, 0);
        check_val("arst_rs1d",  out_rs1_data, 0);
        check_val("arst_rd_ctl", {out_rd, out_wb, out_mem, out_exe}, 0);
        check_val("arst_dbg_x5", dbg_data, 0);
        in_valid = 1'b0;
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check_val("post_rst_valid", out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
